nonlinear_arbiter: RTL and testbench

//  Shares one combinational nonlinear unit (ReLU, fun_id 3'b001) among NUM_REQ

---
 rtl/nonlinear_arbiter.sv | 125 ++++++++++++
 tb/tb_nonlinear_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonlinear_arbiter.sv
// nonlinear_arbiter
// Round-robin front end that lets several requesters share one combinational
// nonlinear unit. A single output register holds each result, tagged with the
// index of the requester that issued it, and supports a same-cycle pop and
// reload so one operation per cycle can flow when the consumer keeps up.

module nonlinear_arbiter #(
   parameter int         WIDTH    = 32,
   parameter int         NUM_REQ  = 4,
   parameter int         ID_W     = 2,
   parameter logic [7:0] FUN_MASK = 8'b00000010
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ*3-1:0]     req_fun,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         nl_in,
   output logic [2:0]               nl_fun_id,
   input  logic [WIDTH-1:0]         nl_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_err,
   output logic [31:0]              op_count
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state;
   state_t            next_state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   hi_idx;
   logic [ID_W-1:0]   lo_idx;
   logic              hi_found;
   logic [ID_W-1:0]   grant_idx;
   logic              any_valid;
   logic              accept;
   logic              grant;
   logic [WIDTH-1:0]  sel_data;
   logic [2:0]        sel_fun;
   logic              fun_ok;

   // Round-robin search: lowest valid index at or above ptr, else lowest overall (wrap)
   always_comb begin
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_idx = ID_W'(i);
            if (ID_W'(i) >= ptr) begin
               hi_idx   = ID_W'(i);
               hi_found = 1'b1;
            end
         end
      end
      any_valid = |req_valid;
      grant_idx = hi_found ? hi_idx : lo_idx;
   end

   // Operand and function of the winning requester
   always_comb begin
      sel_data = '0;
      sel_fun  = 3'b001;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == grant_idx) begin
            sel_data = req_data[i*WIDTH +: WIDTH];
            sel_fun  = req_fun[i*3 +: 3];
         end
      end
      fun_ok = FUN_MASK[sel_fun];
   end

   // Output-stage FSM next state plus handshake and issue outputs; accept is
   // gated by reset so nothing is offered while the block is held in reset
   always_comb begin
      next_state = state;
      accept     = rst & en & ((state == EMPTY) | rsp_ready);
      grant      = accept & any_valid;
      req_ready  = '0;
      nl_in      = '0;
      nl_fun_id  = 3'b001;
      if (grant) begin
         req_ready = NUM_REQ'(1) << grant_idx;
         nl_in     = sel_data;
         nl_fun_id = sel_fun;
      end
      case (state)
         EMPTY: if (grant) next_state = FULL;
         FULL:  if (rsp_ready && !grant) next_state = EMPTY;
         default: next_state = EMPTY;
      endcase
   end

   // State register for the output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= next_state;
   end

   // Response register, rotating pointer and operation counter; only a grant
   // changes them, so a held response stays stable under backpressure
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_err  <= 1'b0;
         op_count <= '0;
      end else if (grant) begin
         ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         rsp_id   <= grant_idx;
         op_count <= op_count + 32'd1;
         rsp_data <= fun_ok ? nl_out : '0;
         rsp_err  <= ~fun_ok;
      end
   end

   assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_nonlinear_arbiter.sv
// tb_nonlinear_arbiter
// Directed scenarios plus a randomized run against a behavioural model of the
// shared ReLU arbiter.

module tb_nonlinear_arbiter;

   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                     clk;
   logic                     rst;
   logic                     en;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ*3-1:0]     req_fun;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         nl_in;
   logic [2:0]               nl_fun_id;
   logic [WIDTH-1:0]         nl_out;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [WIDTH-1:0]         rsp_data;
   logic [ID_W-1:0]          rsp_id;
   logic                     rsp_err;
   logic [31:0]              op_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_ptr;
   bit          m_full;
   logic [31:0] m_data;
   int          m_id;
   bit          m_err;
   logic [31:0] m_count;

   nonlinear_arbiter #(
      .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .FUN_MASK(8'b00000010)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .req_valid(req_valid), .req_data(req_data), .req_fun(req_fun),
      .req_ready(req_ready), .nl_in(nl_in), .nl_fun_id(nl_fun_id),
      .nl_out(nl_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .op_count(op_count)
   );

   // Stand-in for the shared unit: ReLU for fun 1, an obviously wrong value otherwise
   assign nl_out = (nl_fun_id == 3'b001) ? (nl_in[WIDTH-1] ? '0 : nl_in) : ~nl_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] relu(input logic [31:0] x);
      return x[31] ? 32'd0 : x;
   endfunction

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; rsp_ready = 1'b0;
      req_valid = '1; req_data = '0; req_fun = {NUM_REQ{3'b001}};
      #2;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", rsp_valid); end
      checks++; if (op_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", op_count); end
      checks++; if (rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp got data=%h id=%0d err=%0b exp 0/0/0", rsp_data, rsp_id, rsp_err); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0000", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
   endtask

   task automatic test_single();
      rsp_ready = 1'b1; en = 1'b1;
      req_valid = 4'b0001; req_data[0 +: 32] = 32'h0000_0005; req_fun[0 +: 3] = 3'b001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got %b exp 0001", req_ready); end
      checks++; if (nl_in !== 32'h5 || nl_fun_id !== 3'b001) begin errors++; $display("[TB] FAIL single_issue got in=%h fun=%0d exp 5/1", nl_in, nl_fun_id); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h5 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp got v=%0b data=%h id=%0d err=%0b exp 1/5/0/0", rsp_valid, rsp_data, rsp_id, rsp_err); end
      checks++; if (op_count !== 32'd1) begin errors++; $display("[TB] FAIL single_count got %0d exp 1", op_count); end
   endtask

   task automatic test_relu_negative();
      req_valid = 4'b0100; req_data[64 +: 32] = 32'hFFFF_FFF0; req_fun[6 +: 3] = 3'b001;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL neg_ready got %b exp 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL neg_rsp got v=%0b data=%h id=%0d err=%0b exp 1/0/2/0", rsp_valid, rsp_data, rsp_id, rsp_err); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL neg_drain got %0b exp 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      rst = 1'b0; #2; rst = 1'b1;
      en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i*32 +: 32] = 32'h100 + i;
         req_fun[i*3 +: 3] = 3'b001;
      end
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("[TB] FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
         @(posedge clk); #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== 32'h100 + (k % 4)) begin errors++; $display("[TB] FAIL rr_rsp[%0d] got v=%0b id=%0d data=%h exp 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, k % 4, 32'h100 + (k % 4)); end
      end
      checks++; if (op_count !== 32'd8) begin errors++; $display("[TB] FAIL rr_count got %0d exp 8", op_count); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0; req_valid = 4'b0010; req_data[32 +: 32] = 32'h0000_0042;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); end
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'h103) begin errors++; $display("[TB] FAIL bp_hold[%0d] got v=%0b id=%0d data=%h exp 1/3/103", k, rsp_valid, rsp_id, rsp_data); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release got %b exp 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h42) begin errors++; $display("[TB] FAIL bp_rsp got v=%0b id=%0d data=%h exp 1/1/42", rsp_valid, rsp_id, rsp_data); end
      checks++; if (op_count !== 32'd9) begin errors++; $display("[TB] FAIL bp_count got %0d exp 9", op_count); end
   endtask

   task automatic test_unsupported();
      req_valid = 4'b1000; req_data[96 +: 32] = 32'd7; req_fun[9 +: 3] = 3'b010;
      #1;
      checks++; if (req_ready !== 4'b1000 || nl_fun_id !== 3'b010) begin errors++; $display("[TB] FAIL unsup_issue got ready=%b fun=%0d exp 1000/2", req_ready, nl_fun_id); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_id !== 2'd3) begin errors++; $display("[TB] FAIL unsup_rsp got v=%0b err=%0b data=%h id=%0d exp 1/1/0/3", rsp_valid, rsp_err, rsp_data, rsp_id); end
      checks++; if (op_count !== 32'd10) begin errors++; $display("[TB] FAIL unsup_count got %0d exp 10", op_count); end
   endtask

   task automatic test_en_drain();
      en = 1'b0; rsp_ready = 1'b0; req_valid = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) req_fun[i*3 +: 3] = 3'b001;
      #1;
      checks++; if (req_ready !== 4'b0000 || nl_in !== 32'd0 || nl_fun_id !== 3'b001) begin errors++; $display("[TB] FAIL en_idle got ready=%b in=%h fun=%0d exp 0000/0/1", req_ready, nl_in, nl_fun_id); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL en_hold got v=%0b err=%0b exp 1/1", rsp_valid, rsp_err); end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL en_pop_ready got %b exp 0000", req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || op_count !== 32'd10) begin errors++; $display("[TB] FAIL en_drain got v=%0b count=%0d exp 0/10", rsp_valid, op_count); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || op_count !== 32'd11) begin errors++; $display("[TB] FAIL mid_pre got v=%0b id=%0d count=%0d exp 1/0/11", rsp_valid, rsp_id, op_count); end
      rst = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || op_count !== 32'd0 || req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset got v=%0b count=%0d ready=%b exp 0/0/0000", rsp_valid, op_count, req_ready); end
      #1; rst = 1'b1; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr got %b exp 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      checks++; if (rsp_id !== 2'd0 || op_count !== 32'd1) begin errors++; $display("[TB] FAIL mid_post got id=%0d count=%0d exp 0/1", rsp_id, op_count); end
      @(posedge clk); #1;
   endtask

   // Random traffic against the model: the model grants the first valid requester
   // found walking upward from its pointer with wrap, whenever the output slot is
   // free or being popped in the same cycle
   task automatic test_random();
      int g;
      bit acc;
      logic [31:0] g_data;
      logic [2:0]  g_fun;
      rst = 1'b0; req_valid = '0; #2; rst = 1'b1;
      m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_err = 0; m_count = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 400; c++) begin
         en        = ($urandom_range(0, 7) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_valid = 4'($urandom);
         for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*32 +: 32] = $urandom;
            req_fun[i*3 +: 3]    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
         end
         #1;
         acc = en && (!m_full || rsp_ready);
         g = -1;
         if (acc) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
         end
         g_data = (g >= 0) ? req_data[g*32 +: 32] : 32'd0;
         g_fun  = (g >= 0) ? req_fun[g*3 +: 3] : 3'b001;
         checks++; if (req_ready !== ((g >= 0) ? 4'(1 << g) : 4'b0000)) begin errors++; $display("[TB] FAIL rand_ready[%0d] got %b exp %b", c, req_ready, (g >= 0) ? 4'(1 << g) : 4'b0000); end
         checks++; if (nl_in !== g_data || nl_fun_id !== g_fun) begin errors++; $display("[TB] FAIL rand_issue[%0d] got in=%h fun=%0d exp %h/%0d", c, nl_in, nl_fun_id, g_data, g_fun); end
         @(posedge clk);
         if (g >= 0) begin
            m_id    = g;
            m_count = m_count + 1;
            m_err   = (g_fun != 3'b001);
            m_data  = m_err ? 32'd0 : relu(g_data);
            m_full  = 1;
            m_ptr   = (g + 1) % NUM_REQ;
         end else if (m_full && rsp_ready) begin
            m_full = 0;
         end
         #1;
         checks++; if (rsp_valid !== m_full || op_count !== m_count) begin errors++; $display("[TB] FAIL rand_state[%0d] got v=%0b count=%0d exp %0b/%0d", c, rsp_valid, op_count, m_full, m_count); end
         if (m_full) begin
            checks++; if (rsp_data !== m_data || rsp_id !== 2'(m_id) || rsp_err !== m_err) begin errors++; $display("[TB] FAIL rand_rsp[%0d] got data=%h id=%0d err=%0b exp %h/%0d/%0b", c, rsp_data, rsp_id, rsp_err, m_data, m_id, m_err); end
         end
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_single();
      test_relu_negative();
      test_round_robin();
      test_backpressure();
      test_unsupported();
      test_en_drain();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
